// File: rtl/mem_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_rr_arbiter
// Brief    : Round-robin arbiter sharing one r/w/busy memory bus among N masters.
// Revision : 1.0
// ============================================================================
module mem_bus_rr_arbiter #(
  parameter int N  = 3,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      i_req_r,
  input  logic [N-1:0]      i_req_w,
  input  logic [2*N-1:0]    i_req_sz,
  input  logic [AW*N-1:0]   i_req_addr,
  input  logic [DW*N-1:0]   i_req_wdata,
  output logic [DW-1:0]     o_req_rdata,
  output logic [N-1:0]      o_req_busy,
  output logic [N-1:0]      o_grant,
  output logic              o_mem_r,
  output logic              o_mem_w,
  output logic [1:0]        o_mem_sz,
  output logic [AW-1:0]     o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic [DW-1:0]     i_mem_rdata,
  input  logic              i_mem_busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] C_LAST_RST = IW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_owner_nxt;
  logic [IW-1:0]   w_last_nxt;

  logic [N-1:0]    w_act;
  logic            w_xfer;
  logic            w_owner_act;
  logic            w_done;
  logic [IW-1:0]   w_base;
  logic [IW-1:0]   w_pick;
  logic            w_pick_vld;

  assign w_act       = i_req_r | i_req_w;
  assign w_xfer      = (r_state == S_XFER);
  assign w_owner_act = w_act[r_owner];
  assign w_done      = w_xfer & w_owner_act & ~i_mem_busy & ~rst;

  // On completion the finishing owner becomes the rr pointer immediately so
  // the back-to-back pick already rotates past it.
  assign w_base = w_done ? r_owner : r_last;

  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = int'(w_base) + k;
      if (j >= N) j = j - N;
      if (!w_pick_vld && w_act[j] && !(w_done && (j == int'(r_owner)))) begin
        w_pick_vld = 1'b1;
        w_pick     = IW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    if ((r_state == S_IDLE) || w_done) begin
      if (w_done) w_last_nxt = r_owner;
      if (w_pick_vld) begin
        w_state_nxt = S_XFER;
        w_owner_nxt = w_pick;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (!w_owner_act) begin
      // Owner withdrew mid-transaction: abandon without touching the pointer.
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= C_LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    o_mem_r     = 1'b0;
    o_mem_w     = 1'b0;
    o_mem_sz    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_xfer && !rst) begin
      o_mem_r     = i_req_r[r_owner];
      o_mem_w     = i_req_w[r_owner];
      o_mem_sz    = i_req_sz[2*int'(r_owner) +: 2];
      o_mem_addr  = i_req_addr[AW*int'(r_owner) +: AW];
      o_mem_wdata = i_req_wdata[DW*int'(r_owner) +: DW];
    end
  end

  always_comb begin
    o_grant    = '0;
    o_req_busy = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i]    = w_xfer && (int'(r_owner) == i);
      o_req_busy[i] = w_act[i] && !(w_done && (int'(r_owner) == i));
    end
  end

  assign o_req_rdata = w_done ? i_mem_rdata : '0;

endmodule
`default_nettype wire
